vga_sync_gen: RTL and testbench

// - Generates 640x480@60Hz VGA timing from the system clock and drives the pixel coordinates consumed by the pixel/colour mux.
// - Sync and blank outputs are delayed OUT_DELAY clk cycles, matching the mux's registered colour path, so they reach the DAC aligned with dato.
// - Sits directly upstream of the colour mux and drives the VGA connector pins.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_axis_counter.sv | 60 ++++++
 rtl/vga_sync_gen.sv | 134 +++++++++++++
 tb/tb_vga_sync_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_pkg : 640x480@60Hz timing constants and axis phase type
// Rev 1.0
// ------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W    = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } vga_phase_t;

  // Phase a count falls in; zero-width regions are skipped naturally.
  function automatic vga_phase_t phase_of(input logic [CNT_W-1:0] cnt,
                                          input int n_active,
                                          input int n_front,
                                          input int n_sync);
    int c;
    c = int'(cnt);
    if (c < n_active)                        return PH_ACTIVE;
    else if (c < n_active + n_front)         return PH_FRONT;
    else if (c < n_active + n_front + n_sync) return PH_SYNC;
    else                                     return PH_BACK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_axis_counter : position counter and phase FSM for one VGA axis
// Rev 1.0
// ------------------------------------------------------------------
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FRONT  = 16,
  parameter int SYNC   = 96,
  parameter int BACK   = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_cnt,
  output vga_phase_t       o_phase,
  output logic             o_wrap
);

  localparam int               TOTAL = ACTIVE + FRONT + SYNC + BACK;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

  if (TOTAL > (1 << CNT_W)) begin : g_total_check
    $error("vga_axis_counter: TOTAL %0d does not fit the counter", TOTAL);
  end

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  vga_phase_t       r_phase;
  vga_phase_t       w_phase_nxt;
  logic             w_at_last;

  always_comb begin
    w_at_last   = (r_cnt == LAST);
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (i_adv) begin
      w_cnt_nxt   = w_at_last ? '0 : r_cnt + 1'b1;
      w_phase_nxt = phase_of(w_cnt_nxt, ACTIVE, FRONT, SYNC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= PH_ACTIVE;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_phase = r_phase;
  assign o_wrap  = i_adv & w_at_last;

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// vga_sync_gen : VGA timing generator with pixel coordinates and
//                sync/blank delayed to match the colour path
// Rev 1.0
// ------------------------------------------------------------------
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = 2,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   OUT_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] pixelX,
  output logic [CNT_W-1:0] pixelY,
  output logic             pix_en,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             frame_start
);

  if (CLK_DIV < 1 || OUT_DELAY < 0 || OUT_DELAY > 4) begin : g_param_check
    $error("vga_sync_gen: CLK_DIV %0d / OUT_DELAY %0d out of range", CLK_DIV, OUT_DELAY);
  end

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       PIPE_RST = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [DIV_W-1:0] r_div;
  logic             r_pix_en;
  logic             r_live;
  logic             r_frame_start;

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  vga_phase_t       w_h_phase;
  vga_phase_t       w_v_phase;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_video_on;
  logic [2:0]       w_pipe_in;
  logic [2:0]       w_pipe_out;

  // r_live keeps video_on low while held in reset even though both FSMs
  // rest in ACTIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div         <= '0;
      r_pix_en      <= 1'b0;
      r_live        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_pix_en      <= (r_div == DIV_LAST);
      r_live        <= 1'b1;
      r_frame_start <= w_v_wrap;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (r_pix_en),
    .o_cnt   (w_h_cnt),
    .o_phase (w_h_phase),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_adv   (w_h_wrap & r_pix_en),
    .o_cnt   (w_v_cnt),
    .o_phase (w_v_phase),
    .o_wrap  (w_v_wrap)
  );

  assign w_video_on = r_live && (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

  assign w_pipe_in = {(w_h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL,
                      (w_v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL,
                      w_video_on};

  if (OUT_DELAY == 0) begin : g_no_delay
    assign w_pipe_out = w_pipe_in;
  end else begin : g_delay
    logic [2:0] r_pipe [OUT_DELAY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < OUT_DELAY; i++) r_pipe[i] <= PIPE_RST;
      end else begin
        r_pipe[0] <= w_pipe_in;
        for (int i = 1; i < OUT_DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign w_pipe_out = r_pipe[OUT_DELAY-1];
  end

  assign pixelX      = w_h_cnt;
  assign pixelY      = w_v_cnt;
  assign pix_en      = r_pix_en;
  assign video_on    = w_video_on;
  assign hsync       = w_pipe_out[2];
  assign vsync       = w_pipe_out[1];
  assign blank_n     = w_pipe_out[0];
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// tb_vga_sync_gen : directed checks on five builds of vga_sync_gen
// Rev 1.0
// ------------------------------------------------------------------
module tb_vga_sync_gen;

  // M: default, Z: OUT_DELAY=0, T: OUT_DELAY=3, C: CLK_DIV=1, S: tiny frame
  localparam int M = 0, Z = 1, T = 2, C = 3, S = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wire [9:0] px [5];
  wire [9:0] py [5];
  wire       pe [5];
  wire       vo [5];
  wire       hs [5];
  wire       vs [5];
  wire       bn [5];
  wire       fs [5];

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;
  bit mon_on  = 1'b0;

  int hs_low = 0, hs_first_x = -1, t_vfall = -1;
  int t_bfall [3] = '{-1, -1, -1};
  bit seen_b [3]  = '{1'b0, 1'b0, 1'b0};
  bit seen_v = 1'b0;
  int prev_x = 0;
  bit wrap_seen = 1'b0;
  int wrap_x = -1, wrap_y = -1;
  int c1_y0 = 0, c1_hs = 0, c1_pe_low = 0;
  int fs_hi = 0, fs_bad = 0, fs_k1 = -1, fs_k2 = -1, m_fs = 0;
  int s_vs_low = 0, s_vs_first_x = -1, s_vs_first_y = -1;
  bit found;

  always #5 clk = ~clk;

  vga_sync_gen #(.OUT_DELAY(1)) u_main (
    .clk(clk), .rst_n(rst_n), .pixelX(px[M]), .pixelY(py[M]), .pix_en(pe[M]),
    .video_on(vo[M]), .hsync(hs[M]), .vsync(vs[M]), .blank_n(bn[M]), .frame_start(fs[M]));

  vga_sync_gen #(.OUT_DELAY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .pixelX(px[Z]), .pixelY(py[Z]), .pix_en(pe[Z]),
    .video_on(vo[Z]), .hsync(hs[Z]), .vsync(vs[Z]), .blank_n(bn[Z]), .frame_start(fs[Z]));

  vga_sync_gen #(.OUT_DELAY(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .pixelX(px[T]), .pixelY(py[T]), .pix_en(pe[T]),
    .video_on(vo[T]), .hsync(hs[T]), .vsync(vs[T]), .blank_n(bn[T]), .frame_start(fs[T]));

  vga_sync_gen #(.CLK_DIV(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .pixelX(px[C]), .pixelY(py[C]), .pix_en(pe[C]),
    .video_on(vo[C]), .hsync(hs[C]), .vsync(vs[C]), .blank_n(bn[C]), .frame_start(fs[C]));

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .OUT_DELAY(1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pixelX(px[S]), .pixelY(py[S]), .pix_en(pe[S]),
    .video_on(vo[S]), .hsync(hs[S]), .vsync(vs[S]), .blank_n(bn[S]), .frame_start(fs[S]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample on the falling edge, then accumulate timing statistics.
  task automatic tick();
    @(negedge clk);
    k++;
    if (mon_on) begin
      if (hs[M] === 1'b0) begin
        if (hs_low == 0) hs_first_x = int'(px[M]);
        hs_low++;
      end
      if (vo[M] === 1'b1) seen_v = 1'b1;
      else if (seen_v && t_vfall < 0) t_vfall = k;
      for (int i = 0; i < 3; i++) begin
        if (bn[i] === 1'b1) seen_b[i] = 1'b1;
        else if (seen_b[i] && t_bfall[i] < 0) t_bfall[i] = k;
      end
      if (prev_x == 799 && int'(px[M]) != 799 && !wrap_seen) begin
        wrap_seen = 1'b1;
        wrap_x    = int'(px[M]);
        wrap_y    = int'(py[M]);
      end
      prev_x = int'(px[M]);
      if (fs[M] === 1'b1) m_fs++;
      if (py[C] == 10'd0) c1_y0++;
      if (py[C] == 10'd0 && hs[C] === 1'b0) c1_hs++;
      if (pe[C] !== 1'b1) c1_pe_low++;
      if (fs_k1 < 0 && vs[S] === 1'b0) begin
        if (s_vs_low == 0) begin
          s_vs_first_x = int'(px[S]);
          s_vs_first_y = int'(py[S]);
        end
        s_vs_low++;
      end
      if (fs[S] === 1'b1) begin
        fs_hi++;
        if (px[S] != 10'd0 || py[S] != 10'd0) fs_bad++;
        if (fs_k1 < 0) fs_k1 = k;
        else if (fs_k2 < 0) fs_k2 = k;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (5) tick();
    chk("rst_pixelX", px[M], 0);
    chk("rst_pixelY", py[M], 0);
    chk("rst_pix_en", pe[M], 0);
    chk("rst_video_on", vo[M], 0);
    chk("rst_frame_start", fs[M], 0);
    chk("rst_hsync", hs[M], 1);
    chk("rst_vsync", vs[M], 1);
    chk("rst_blank_n", bn[M], 0);
    chk("rst_blank_n_d0", bn[Z], 0);
    chk("rst_pix_en_c1", pe[C], 0);

    // Release and first pixel enables
    rst_n  = 1'b1;
    k      = 0;
    mon_on = 1'b1;
    tick();
    chk("k1_pix_en", pe[M], 0);
    chk("k1_video_on", vo[M], 1);
    chk("k1_blank_n", bn[M], 0);
    chk("k1_blank_n_d0", bn[Z], 1);
    chk("k1_blank_n_d3", bn[T], 0);
    chk("k1_pix_en_c1", pe[C], 1);
    chk("k1_pixelX_c1", px[C], 0);
    chk("k1_hsync", hs[M], 1);
    chk("k1_vsync", vs[M], 1);
    tick();
    chk("k2_pix_en", pe[M], 1);
    chk("k2_pixelX", px[M], 0);
    chk("k2_blank_n", bn[M], 1);
    chk("k2_blank_n_d3", bn[T], 0);
    chk("k2_pixelX_c1", px[C], 1);
    tick();
    chk("k3_pixelX", px[M], 1);
    chk("k3_pix_en", pe[M], 0);
    chk("k3_blank_n_d3", bn[T], 0);
    tick();
    chk("k4_blank_n_d3", bn[T], 1);
    chk("k4_pixelX", px[M], 1);

    // Run the first full line of the default build
    for (int i = 0; i < 2000 && py[M] != 10'd1; i++) tick();
    chk("line_done", py[M], 1);
    chk("line_end_k", k, 1601);
    chk("hsync_low_clks", hs_low, 192);
    chk("hsync_start_x", hs_first_x, 656);
    chk("wrap_seen", wrap_seen, 1);
    chk("wrap_x", wrap_x, 0);
    chk("wrap_y", wrap_y, 1);
    chk("video_fall_k", t_vfall, 1281);
    chk("blank_fall_lag_d1", t_bfall[0] - t_vfall, 1);
    chk("blank_fall_lag_d0", t_bfall[1] - t_vfall, 0);
    chk("blank_fall_lag_d3", t_bfall[2] - t_vfall, 3);
    chk("main_frame_start_cnt", m_fs, 0);
    chk("c1_line_clks", c1_y0, 800);
    chk("c1_hsync_clks", c1_hs, 96);
    chk("c1_pix_en_low", c1_pe_low, 0);
    chk("s_frame_first_k", fs_k1, 241);
    chk("s_frame_period", fs_k2 - fs_k1, 240);
    chk("s_frame_pulses", fs_hi, 6);
    chk("s_frame_not_00", fs_bad, 0);
    chk("s_vsync_low_clks", s_vs_low, 60);
    chk("s_vsync_first_y", s_vs_first_y, 5);
    chk("s_vsync_first_x", s_vs_first_x, 0);
    mon_on = 1'b0;

    // Mid-frame asynchronous reset inside both sync pulses of the tiny build
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (px[S] == 10'd11 && py[S] == 10'd5) found = 1'b1;
    end
    chk("mid_target_found", found, 1);
    chk("mid_pre_hsync", hs[S], 0);
    chk("mid_pre_vsync", vs[S], 0);
    rst_n = 1'b0;
    #1;
    chk("mid_pixelX", px[S], 0);
    chk("mid_pixelY", py[S], 0);
    chk("mid_hsync", hs[S], 1);
    chk("mid_vsync", vs[S], 1);
    chk("mid_blank_n", bn[S], 0);
    chk("mid_video_on", vo[S], 0);
    chk("mid_pix_en", pe[S], 0);
    chk("mid_frame_start", fs[S], 0);
    chk("mid_main_pixelX", px[M], 0);
    chk("mid_main_pixelY", py[M], 0);
    repeat (3) tick();
    rst_n = 1'b1;
    k     = 0;
    tick();
    chk("re_k1_video_on", vo[S], 1);
    chk("re_k1_pix_en", pe[S], 0);
    tick();
    chk("re_k2_pix_en", pe[S], 1);
    chk("re_k2_pixelX", px[S], 0);
    tick();
    chk("re_k3_pixelX", px[S], 1);
    chk("re_k3_pixelY", py[S], 0);
    chk("re_k3_main_pixelX", px[M], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
